// File: rtl/lstm_gate_mac_ctrl_if.sv
// Bundle of gate request/result, operand memory and shared mult/add signals.
// master = sequencer side, slave = gate engines / memories / datapath side.
interface lstm_gate_mac_ctrl_if #(
    parameter int DATA_WIDTH   = 14,
    parameter int OUTPUT_WIDTH = 28,
    parameter int ADDR_W       = 4
);
    logic [3:0]              req;
    logic [3:0]              grant;
    logic                    rd_en;
    logic [ADDR_W-1:0]       rd_addr;
    logic [1:0]              rd_gate;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH-1:0]   x_data;
    logic [DATA_WIDTH-1:0]   mult_a;
    logic [DATA_WIDTH-1:0]   mult_b;
    logic [OUTPUT_WIDTH-1:0] mult_p;
    logic [OUTPUT_WIDTH-1:0] add_a;
    logic [OUTPUT_WIDTH-1:0] add_b;
    logic                    add_cin;
    logic [OUTPUT_WIDTH-1:0] add_s;
    logic                    res_valid;
    logic [OUTPUT_WIDTH-1:0] res_data;
    logic [1:0]              res_gate;
    logic                    res_sat;
    logic                    busy;

    modport master (
        input  req, w_data, x_data, mult_p, add_s,
        output grant, rd_en, rd_addr, rd_gate, mult_a, mult_b,
               add_a, add_b, add_cin, res_valid, res_data, res_gate, res_sat, busy
    );

    modport slave (
        output req, w_data, x_data, mult_p, add_s,
        input  grant, rd_en, rd_addr, rd_gate, mult_a, mult_b,
               add_a, add_b, add_cin, res_valid, res_data, res_gate, res_sat, busy
    );
endinterface

// File: rtl/lstm_gate_mac_ctrl.sv
// Round-robin sequencer sharing one mult/add pair across four LSTM gate engines.
// Optional accumulator saturation enabled by defining MAC_SAT_EN.
module lstm_gate_mac_ctrl #(
    parameter int DATA_WIDTH   = 14,
    parameter int OUTPUT_WIDTH = 28,
    parameter int VEC_LEN      = 16,
    parameter int ADDR_W       = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    lstm_gate_mac_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam int MSB = OUTPUT_WIDTH - 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VEC_LEN - 1);

    state_t                  state, state_nx;
    logic [1:0]              gate;
    logic [1:0]              ptr;
    logic [1:0]              winner;
    logic                    start;
    logic [ADDR_W-1:0]       cnt;
    logic                    v_rd, v_m, v_p;
    logic [DATA_WIDTH-1:0]   ma, mb;
    logic [OUTPUT_WIDTH-1:0] prod;
    logic [OUTPUT_WIDTH-1:0] acc;
    logic                    sat;

    assign start = (state == IDLE) && (|bus.req);

    // First requester at or after the pointer, wrapping modulo 4.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (|bus.req) state_nx = ISSUE;
            ISSUE: if (cnt == LAST_ADDR) state_nx = DRAIN;
            DRAIN: if (v_p && !v_m && !v_rd) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gate  <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                gate <= winner;
                ptr  <= winner + 2'd1;
                cnt  <= '0;
            end else if (state == ISSUE) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Read -> operand regs -> product reg -> accumulator, valid bit per stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_rd <= 1'b0;
            v_m  <= 1'b0;
            v_p  <= 1'b0;
            ma   <= '0;
            mb   <= '0;
            prod <= '0;
        end else begin
            v_rd <= (state == ISSUE);
            v_m  <= v_rd;
            v_p  <= v_m;
            if (v_rd) begin
                ma <= bus.w_data;
                mb <= bus.x_data;
            end
            if (v_m) prod <= bus.mult_p;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            sat <= 1'b0;
        end else if (start) begin
            acc <= '0;
            sat <= 1'b0;
        end else if (v_p) begin
`ifdef MAC_SAT_EN
            // Once clamped, the accumulator holds its rail until the result.
            if (!sat) begin
                if ((acc[MSB] == prod[MSB]) && (bus.add_s[MSB] != acc[MSB])) begin
                    acc <= acc[MSB] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}}
                                    : {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
                    sat <= 1'b1;
                end else begin
                    acc <= bus.add_s;
                end
            end
`else
            acc <= bus.add_s;
            sat <= 1'b0;
`endif
        end
    end

    assign bus.grant     = (state != IDLE) ? (4'b0001 << gate) : 4'b0000;
    assign bus.busy      = (state != IDLE);
    assign bus.rd_en     = (state == ISSUE);
    assign bus.rd_addr   = cnt;
    assign bus.rd_gate   = gate;
    assign bus.mult_a    = ma;
    assign bus.mult_b    = mb;
    assign bus.add_a     = acc;
    assign bus.add_b     = prod;
    assign bus.add_cin   = 1'b0;
    assign bus.res_valid = (state == DONE);
    assign bus.res_data  = (state == DONE) ? acc : '0;
    assign bus.res_gate  = gate;
    assign bus.res_sat   = (state == DONE) && sat;
endmodule

// File: tb/tb_lstm_gate_mac_ctrl.sv
// Directed self-checking bench for lstm_gate_mac_ctrl with memory, multiplier
// and adder models; expectations follow MAC_SAT_EN when it is defined.
module tb_lstm_gate_mac_ctrl;
    localparam int DW  = 14;
    localparam int OW  = 28;
    localparam int VL  = 16;
    localparam int AW  = 4;
    localparam int LAT = VL + 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;

    logic [DW-1:0] w_val = '0;
    logic [DW-1:0] x_val = '0;
    bit            gate_mode = 1'b0;
    bit            idx_mode = 1'b0;

    lstm_gate_mac_ctrl_if #(.DATA_WIDTH(DW), .OUTPUT_WIDTH(OW), .ADDR_W(AW)) bus ();

    lstm_gate_mac_ctrl #(.DATA_WIDTH(DW), .OUTPUT_WIDTH(OW), .VEC_LEN(VL), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Operand memories: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.w_data <= w_val + (gate_mode ? {12'b0, bus.rd_gate} : 14'd0);
            bus.x_data <= idx_mode ? {10'b0, bus.rd_addr} : x_val;
        end
    end
    initial begin
        bus.w_data = '0;
        bus.x_data = '0;
        bus.req    = '0;
    end

    logic signed [OW-1:0] sa, sb;
    assign sa         = {{(OW-DW){bus.mult_a[DW-1]}}, bus.mult_a};
    assign sb         = {{(OW-DW){bus.mult_b[DW-1]}}, bus.mult_b};
    assign bus.mult_p = sa * sb;
    assign bus.add_s  = bus.add_a + bus.add_b + {{(OW-1){1'b0}}, bus.add_cin};

    task automatic test_reset();
        tests++;
        if ({bus.grant, bus.rd_en, bus.rd_addr, bus.rd_gate, bus.busy} !== 12'h0) begin
            failed++;
            $display("FAIL reset_ctrl got grant=%b rd_en=%b rd_addr=%0d rd_gate=%0d busy=%b want 0",
                     bus.grant, bus.rd_en, bus.rd_addr, bus.rd_gate, bus.busy);
        end
        tests++;
        if ({bus.mult_a, bus.mult_b, bus.add_a, bus.add_b, bus.add_cin} !== '0) begin
            failed++;
            $display("FAIL reset_dp got ma=%h mb=%h aa=%h ab=%h cin=%b want 0",
                     bus.mult_a, bus.mult_b, bus.add_a, bus.add_b, bus.add_cin);
        end
        tests++;
        if ({bus.res_valid, bus.res_data, bus.res_gate, bus.res_sat} !== '0) begin
            failed++;
            $display("FAIL reset_res got v=%b d=%h g=%0d s=%b want 0",
                     bus.res_valid, bus.res_data, bus.res_gate, bus.res_sat);
        end
    endtask

    // One request to completion; returns the grant cycle.
    task automatic run_op(input string nm, input logic [3:0] r, input logic [1:0] eg,
                          input logic [OW-1:0] ed, input logic es, output int g);
        bit ok;
        int rdc;
        @(negedge clk);
        bus.req = r;
        ok = 1'b0;
        g = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.grant !== 4'b0000) begin ok = 1'b1; break; end
        end
        tests++;
        if (!ok) begin
            failed++;
            $display("FAIL %s_grant_timeout got grant=%b want %b", nm, bus.grant, 4'b0001 << eg);
            bus.req = '0;
            return;
        end
        g = cyc;
        if (bus.grant !== (4'b0001 << eg) || bus.busy !== 1'b1) begin
            failed++;
            $display("FAIL %s_grant got grant=%b busy=%b want %b busy=1", nm, bus.grant, bus.busy,
                     4'b0001 << eg);
        end
        rdc = int'(bus.rd_en);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) begin ok = 1'b1; break; end
            rdc += int'(bus.rd_en);
        end
        tests++;
        if (!ok) begin
            failed++;
            $display("FAIL %s_result_timeout got no res_valid want one at G+%0d", nm, LAT);
        end else if (cyc - g != LAT || rdc != VL) begin
            failed++;
            $display("FAIL %s_timing got latency=%0d reads=%0d want latency=%0d reads=%0d",
                     nm, cyc - g, rdc, LAT, VL);
        end
        tests++;
        if (bus.res_data !== ed || bus.res_gate !== eg || bus.res_sat !== es) begin
            failed++;
            $display("FAIL %s_result got data=%h gate=%0d sat=%b want data=%h gate=%0d sat=%b",
                     nm, bus.res_data, bus.res_gate, bus.res_sat, ed, eg, es);
        end
        bus.req = '0;
        @(negedge clk);
        tests++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
            failed++;
            $display("FAIL %s_release got grant=%b busy=%b v=%b want 0 0 0",
                     nm, bus.grant, bus.busy, bus.res_valid);
        end
    endtask

    task automatic test_basic();
        int g;
        w_val = 14'd1; x_val = 14'd3; gate_mode = 0; idx_mode = 0;
        run_op("basic", 4'b0100, 2'd2, 28'd48, 1'b0, g);
    endtask

    task automatic test_negative();
        int g;
        w_val = 14'h3FFE; x_val = 14'd5;
        run_op("negative", 4'b0001, 2'd0, 28'hFFFFF60, 1'b0, g);
    endtask

    task automatic test_saturation();
        int g;
        w_val = 14'h1FFF; x_val = 14'h1FFF;
`ifdef MAC_SAT_EN
        run_op("saturation", 4'b0001, 2'd0, 28'h7FFFFFF, 1'b1, g);
`else
        run_op("saturation", 4'b0001, 2'd0, 28'hFFC0010, 1'b0, g);
`endif
    endtask

    task automatic test_index();
        int g;
        w_val = 14'd1; idx_mode = 1;
        run_op("index", 4'b1000, 2'd3, 28'd120, 1'b0, g);
        idx_mode = 0;
    endtask

    task automatic test_back_to_back();
        int  gprev;
        bit  ok;
        w_val = 14'd1; x_val = 14'd3; gate_mode = 1;
        gprev = 0;
        @(negedge clk);
        bus.req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (bus.grant !== 4'b0000) begin ok = 1'b1; break; end
            end
            tests++;
            if (!ok || bus.grant !== (4'b0001 << k) || (k > 0 && cyc - gprev != VL + 5)) begin
                failed++;
                $display("FAIL b2b_grant%0d got grant=%b gap=%0d want %b gap=%0d",
                         k, bus.grant, cyc - gprev, 4'b0001 << k, VL + 5);
            end
            gprev = cyc;
            ok = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (bus.res_valid === 1'b1) begin ok = 1'b1; break; end
            end
            tests++;
            if (!ok || bus.res_gate !== 2'(k) || bus.res_data !== OW'(48 * (k + 1))) begin
                failed++;
                $display("FAIL b2b_result%0d got v=%b gate=%0d data=%0d want gate=%0d data=%0d",
                         k, bus.res_valid, bus.res_gate, bus.res_data, k, 48 * (k + 1));
            end
        end
        bus.req = '0;
        gate_mode = 0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int g;
        w_val = 14'd1; x_val = 14'd3;
        run_op("rr_first", 4'b0010, 2'd1, 28'd48, 1'b0, g);
        run_op("rr_wrap", 4'b0011, 2'd0, 28'd48, 1'b0, g);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int g;
        int seen;
        w_val = 14'd2; x_val = 14'd7;
        @(negedge clk);
        bus.req = 4'b0010;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.grant !== 4'b0000) begin ok = 1'b1; break; end
        end
        tests++;
        if (!ok || bus.grant !== 4'b0010) begin
            failed++;
            $display("FAIL midrst_grant got grant=%b want 0010", bus.grant);
        end
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        test_reset();
        bus.req = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            seen += int'(bus.res_valid === 1'b1);
        end
        tests++;
        if (seen != 0) begin
            failed++;
            $display("FAIL midrst_no_result got %0d res_valid pulses want 0", seen);
        end
        run_op("after_reset", 4'b1111, 2'd0, 28'd224, 1'b0, g);
        run_op("after_reset_g1", 4'b0010, 2'd1, 28'd224, 1'b0, g);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_negative();
        test_saturation();
        test_index();
        test_back_to_back();
        test_round_robin();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
